keypad_lock_ctrl: RTL and testbench



---
 rtl/keypad_pkg.sv | 37 +++
 rtl/lock_timer.sv | 41 ++++
 rtl/keypad_lock_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_keypad_lock_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_pkg
//  Purpose  : Shared key codes, FSM state encoding and helpers for the
//             keypad lock controller.
//  Contents : KEY_NONE / KEY_STAR / KEY_HASH key codes, state_t enum,
//             nibble_mask() helper.
//  Revision : 1.0  initial release
// ============================================================================
package keypad_pkg;

    localparam logic [3:0] KEY_NONE = 4'd15;
    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd12;

    typedef enum logic [2:0] {
        ST_ENTRY   = 3'd0,
        ST_CHECK   = 3'd1,
        ST_OPEN    = 3'd2,
        ST_PROGRAM = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_t;

    // Mask selecting the low 'len' nibbles of a 16-bit digit buffer.
    function automatic logic [15:0] nibble_mask(input int len);
        logic [15:0] m;
        m = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            if (i < len) begin
                m[4*i +: 4] = 4'hF;
            end
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lock_timer.sv
`default_nettype none
// ============================================================================
//  Module   : lock_timer
//  Purpose  : Loadable down-counter used for the open and lockout windows.
//  Ports    : clk, rst_n     - clock, asynchronous active-low reset
//             load, load_val - load the counter (has priority over en)
//             en             - count down while high
//             expired        - high in the cycle the count steps 1 -> 0, so a
//                              load of N followed by N enabled cycles expires
//                              exactly N cycles after the load
//  Revision : 1.0  initial release
// ============================================================================
module lock_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             expired
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    // Expiry is flagged on the final decrement rather than once the count
    // already sits at zero, which keeps the window exactly load_val long.
    assign expired = en && (r_count == WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/keypad_lock_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_lock_ctrl
//  Purpose  : Digital-locker PIN controller fed by a keypad key-code stream:
//             digit entry, PIN check, timed unlock, PIN reprogramming and
//             lockout after repeated failures.
//  Ports    : clk, rst_n  - clock, asynchronous active-low reset
//             key_code    - 0-9 digit, 10 '*', 12 '#', 15 none
//             unlocked    - lock released (OPEN / PROGRAM)
//             alarm       - high throughout lockout
//             err_pulse   - one-cycle pulse: failed check / invalid program
//             ok_pulse    - one-cycle pulse: good check / PIN programmed
//             state_o     - current FSM state (debug)
//             entry_cnt   - digits held in the entry buffer
//             entry_disp  - entry buffer, newest digit in nibble 0, unused
//                           nibbles 4'hF
//  Revision : 1.0  initial release
// ============================================================================
module keypad_lock_ctrl
    import keypad_pkg::*;
#(
    parameter int          PIN_LEN        = 4,
    parameter logic [15:0] DEFAULT_PIN    = 16'h1234,
    parameter int          UNLOCK_CYCLES  = 36_000_000,
    parameter int          MAX_FAIL       = 3,
    parameter int          LOCKOUT_CYCLES = 120_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  key_code,
    output logic        unlocked,
    output logic        alarm,
    output logic        err_pulse,
    output logic        ok_pulse,
    output logic [2:0]  state_o,
    output logic [2:0]  entry_cnt,
    output logic [15:0] entry_disp
);

    localparam int TMR_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int FAIL_W  = $clog2(MAX_FAIL + 1);

    localparam logic [TMR_W-1:0]  c_unlock_val  = TMR_W'(UNLOCK_CYCLES);
    localparam logic [TMR_W-1:0]  c_lockout_val = TMR_W'(LOCKOUT_CYCLES);
    localparam logic [15:0]       c_pin_mask    = nibble_mask(PIN_LEN);
    localparam logic [2:0]        c_pin_len     = 3'(PIN_LEN);
    localparam logic [FAIL_W-1:0] c_max_fail    = FAIL_W'(MAX_FAIL);

    // Key input register and previous value for edge-style event detection.
    logic [3:0] r_key_q;
    logic [3:0] r_key_prev;
    logic       w_key_event;
    logic       w_is_digit;
    logic       w_is_star;
    logic       w_is_hash;

    state_t            r_state,  w_state_nxt;
    logic [15:0]       r_buf,    w_buf_nxt;
    logic [2:0]        r_cnt,    w_cnt_nxt;
    logic [15:0]       r_pin,    w_pin_nxt;
    logic [FAIL_W-1:0] r_fail,   w_fail_nxt;
    logic              r_ok,     w_ok_nxt;
    logic              r_err,    w_err_nxt;

    logic              w_tmr_load;
    logic [TMR_W-1:0]  w_tmr_val;
    logic              w_tmr_en;
    logic              w_tmr_expired;

    logic              w_room;
    logic              w_match;
    logic [FAIL_W-1:0] w_fail_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_q    <= KEY_NONE;
            r_key_prev <= KEY_NONE;
        end else begin
            r_key_q    <= key_code;
            r_key_prev <= r_key_q;
        end
    end

    // A held code yields a single event; KEY_NONE never does.
    assign w_key_event = (r_key_q != KEY_NONE) && (r_key_q != r_key_prev);
    assign w_is_digit  = w_key_event && (r_key_q <= 4'd9);
    assign w_is_star   = w_key_event && (r_key_q == KEY_STAR);
    assign w_is_hash   = w_key_event && (r_key_q == KEY_HASH);

    assign w_room     = (r_cnt < c_pin_len);
    assign w_match    = (r_cnt == c_pin_len) && ((r_buf & c_pin_mask) == (r_pin & c_pin_mask));
    assign w_fail_inc = r_fail + 1'b1;

    lock_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_tmr_load),
        .load_val (w_tmr_val),
        .en       (w_tmr_en),
        .expired  (w_tmr_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ENTRY;
            r_buf   <= 16'hFFFF;
            r_cnt   <= 3'd0;
            r_pin   <= DEFAULT_PIN;
            r_fail  <= '0;
            r_ok    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_buf   <= w_buf_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pin   <= w_pin_nxt;
            r_fail  <= w_fail_nxt;
            r_ok    <= w_ok_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_buf_nxt   = r_buf;
        w_cnt_nxt   = r_cnt;
        w_pin_nxt   = r_pin;
        w_fail_nxt  = r_fail;
        w_ok_nxt    = 1'b0;
        w_err_nxt   = 1'b0;
        w_tmr_load  = 1'b0;
        w_tmr_val   = c_unlock_val;
        w_tmr_en    = 1'b0;

        case (r_state)
            ST_ENTRY: begin
                if (w_is_digit) begin
                    if (w_room) begin
                        w_buf_nxt = {r_buf[11:0], r_key_q};
                        w_cnt_nxt = r_cnt + 3'd1;
                    end
                end else if (w_is_star) begin
                    w_buf_nxt = 16'hFFFF;
                    w_cnt_nxt = 3'd0;
                end else if (w_is_hash) begin
                    w_state_nxt = ST_CHECK;
                end
            end

            ST_CHECK: begin
                w_buf_nxt  = 16'hFFFF;
                w_cnt_nxt  = 3'd0;
                w_tmr_load = 1'b1;
                if (w_match) begin
                    w_ok_nxt    = 1'b1;
                    w_fail_nxt  = '0;
                    w_tmr_val   = c_unlock_val;
                    w_state_nxt = ST_OPEN;
                end else begin
                    w_err_nxt  = 1'b1;
                    w_fail_nxt = w_fail_inc;
                    w_tmr_val  = c_lockout_val;
                    if (w_fail_inc == c_max_fail) begin
                        w_state_nxt = ST_LOCKOUT;
                    end else begin
                        w_state_nxt = ST_ENTRY;
                    end
                end
            end

            ST_OPEN: begin
                w_tmr_en = 1'b1;
                // Expiry is tested first so a coincident key is discarded.
                if (w_tmr_expired || w_is_star) begin
                    w_state_nxt = ST_ENTRY;
                end else if (w_is_hash) begin
                    w_tmr_load  = 1'b1;
                    w_state_nxt = ST_PROGRAM;
                end
            end

            ST_PROGRAM: begin
                w_tmr_en = 1'b1;
                if (w_tmr_expired) begin
                    w_buf_nxt   = 16'hFFFF;
                    w_cnt_nxt   = 3'd0;
                    w_state_nxt = ST_ENTRY;
                end else if (w_key_event) begin
                    // Any activity keeps the programming window alive.
                    w_tmr_load = 1'b1;
                    if (w_is_digit) begin
                        if (w_room) begin
                            w_buf_nxt = {r_buf[11:0], r_key_q};
                            w_cnt_nxt = r_cnt + 3'd1;
                        end
                    end else if (w_is_star) begin
                        w_buf_nxt   = 16'hFFFF;
                        w_cnt_nxt   = 3'd0;
                        w_state_nxt = ST_ENTRY;
                    end else if (w_is_hash) begin
                        w_buf_nxt = 16'hFFFF;
                        w_cnt_nxt = 3'd0;
                        if (r_cnt == c_pin_len) begin
                            w_pin_nxt   = r_buf;
                            w_ok_nxt    = 1'b1;
                            w_state_nxt = ST_ENTRY;
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                    end
                end
            end

            ST_LOCKOUT: begin
                w_tmr_en  = 1'b1;
                w_buf_nxt = 16'hFFFF;
                w_cnt_nxt = 3'd0;
                if (w_tmr_expired) begin
                    w_fail_nxt  = '0;
                    w_state_nxt = ST_ENTRY;
                end
            end

            default: begin
                w_buf_nxt   = 16'hFFFF;
                w_cnt_nxt   = 3'd0;
                w_state_nxt = ST_ENTRY;
            end
        endcase
    end

    assign unlocked   = (r_state == ST_OPEN) || (r_state == ST_PROGRAM);
    assign alarm      = (r_state == ST_LOCKOUT);
    assign ok_pulse   = r_ok;
    assign err_pulse  = r_err;
    assign state_o    = r_state;
    assign entry_cnt  = r_cnt;
    assign entry_disp = r_buf;

endmodule
`default_nettype wire

// File: tb/tb_keypad_lock_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keypad_lock_ctrl
//  Purpose  : Self-checking bench for keypad_lock_ctrl with a queue-based
//             behavioural model, directed scenarios and random key traffic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_keypad_lock_ctrl;

    localparam int          PIN_LEN  = 4;
    localparam logic [15:0] DEF_PIN  = 16'h1234;
    localparam int          UNLOCK   = 20;
    localparam int          MAX_FAIL = 3;
    localparam int          LOCKOUT  = 50;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  key_code;
    logic        unlocked;
    logic        alarm;
    logic        err_pulse;
    logic        ok_pulse;
    logic [2:0]  state_o;
    logic [2:0]  entry_cnt;
    logic [15:0] entry_disp;

    keypad_lock_ctrl #(
        .PIN_LEN        (PIN_LEN),
        .DEFAULT_PIN    (DEF_PIN),
        .UNLOCK_CYCLES  (UNLOCK),
        .MAX_FAIL       (MAX_FAIL),
        .LOCKOUT_CYCLES (LOCKOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_code   (key_code),
        .unlocked   (unlocked),
        .alarm      (alarm),
        .err_pulse  (err_pulse),
        .ok_pulse   (ok_pulse),
        .state_o    (state_o),
        .entry_cnt  (entry_cnt),
        .entry_disp (entry_disp)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 entry, 1 check, 2 open, 3 program, 4 lockout
    int m_mode;
    int m_q[$];          // entered digits, oldest first
    int m_pin[PIN_LEN];  // PIN digits, first digit at index 0
    int m_fail;
    int m_rem;           // cycles left in the current timed window
    bit m_ok, m_err;
    int h1, h2;          // key seen one and two clocks ago

    task automatic model_reset();
        m_mode = 0;
        m_q.delete();
        for (int i = 0; i < PIN_LEN; i++)
            m_pin[i] = int'((DEF_PIN >> (4 * (PIN_LEN - 1 - i))) & 16'hF);
        m_fail = 0;
        m_rem  = 0;
        m_ok   = 0;
        m_err  = 0;
        h1     = 15;
        h2     = 15;
    endtask

    task automatic model_step();
        bit ev, expire, match;
        int k;
        k      = h1;
        ev     = (h1 != 15) && (h1 != h2);
        expire = (m_mode >= 2) && (m_rem == 1);
        if (m_mode >= 2 && m_rem > 0) m_rem--;
        m_ok  = 0;
        m_err = 0;
        case (m_mode)
            0: if (ev) begin
                if (k <= 9) begin
                    if (m_q.size() < PIN_LEN) m_q.push_back(k);
                end else if (k == 10) m_q.delete();
                else if (k == 12) m_mode = 1;
            end
            1: begin
                match = (m_q.size() == PIN_LEN);
                if (match)
                    for (int i = 0; i < PIN_LEN; i++)
                        if (m_q[i] != m_pin[i]) match = 0;
                m_q.delete();
                if (match) begin
                    m_ok = 1; m_fail = 0; m_rem = UNLOCK; m_mode = 2;
                end else begin
                    m_err = 1; m_fail++;
                    if (m_fail == MAX_FAIL) begin m_mode = 4; m_rem = LOCKOUT; end
                    else m_mode = 0;
                end
            end
            2: begin
                if (expire) m_mode = 0;
                else if (ev && k == 10) m_mode = 0;
                else if (ev && k == 12) begin m_mode = 3; m_rem = UNLOCK; end
            end
            3: begin
                if (expire) begin
                    m_mode = 0; m_q.delete();
                end else if (ev) begin
                    m_rem = UNLOCK;
                    if (k <= 9) begin
                        if (m_q.size() < PIN_LEN) m_q.push_back(k);
                    end else if (k == 10) begin
                        m_q.delete(); m_mode = 0;
                    end else if (k == 12) begin
                        if (m_q.size() == PIN_LEN) begin
                            for (int i = 0; i < PIN_LEN; i++) m_pin[i] = m_q[i];
                            m_ok = 1; m_mode = 0;
                        end else m_err = 1;
                        m_q.delete();
                    end
                end
            end
            default: begin
                m_q.delete();
                if (expire) begin m_fail = 0; m_mode = 0; end
            end
        endcase
        h2 = h1;
        h1 = int'(key_code);
    endtask

    function automatic logic [15:0] exp_disp();
        logic [15:0] d;
        d = 16'hFFFF;
        for (int i = 0; i < m_q.size(); i++)
            d[4*i +: 4] = 4'(m_q[m_q.size() - 1 - i]);
        return d;
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // ---------------- compare process + activity counters ----------------
    int ok_cnt, err_cnt, unl_cnt, alm_cnt;

    initial begin
        forever begin
            @(negedge clk);
            check("unlocked",   32'(unlocked),   32'(m_mode == 2 || m_mode == 3));
            check("alarm",      32'(alarm),      32'(m_mode == 4));
            check("ok_pulse",   32'(ok_pulse),   32'(m_ok));
            check("err_pulse",  32'(err_pulse),  32'(m_err));
            check("state_o",    32'(state_o),    32'(m_mode));
            check("entry_cnt",  32'(entry_cnt),  32'(m_q.size()));
            check("entry_disp", 32'(entry_disp), 32'(exp_disp()));
            ok_cnt  += int'(ok_pulse);
            err_cnt += int'(err_pulse);
            unl_cnt += int'(unlocked);
            alm_cnt += int'(alarm);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_counts();
        ok_cnt = 0; err_cnt = 0; unl_cnt = 0; alm_cnt = 0;
    endtask

    task automatic press(input logic [3:0] k);
        @(negedge clk);
        key_code = k;
        repeat (3) @(negedge clk);
        key_code = 4'd15;
        repeat (2) @(negedge clk);
    endtask

    task automatic press_pin(input logic [31:0] digits, input int n);
        for (int i = n - 1; i >= 0; i--) press(digits[4*i +: 4]);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        key_code = 4'd15;
        clear_counts();
        wait_cyc(3);
        check("rst_state",    32'(state_o),    32'd0);
        check("rst_disp",     32'(entry_disp), 32'hFFFF);
        check("rst_cnt",      32'(entry_cnt),  32'd0);
        check("rst_unlocked", 32'(unlocked),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(2);

        // 1: correct PIN unlocks for exactly UNLOCK cycles
        clear_counts();
        press_pin(32'h1234, 4);
        #1;
        check("t1_disp_before_hash", 32'(entry_disp), 32'h1234);
        press(4'd12);
        wait_cyc(30);
        check("t1_ok_count",     32'(ok_cnt),   32'd1);
        check("t1_unlock_len",   32'(unl_cnt),  32'd20);
        check("t1_relocked",     32'(unlocked), 32'd0);

        // 2: three failures -> lockout, keys ignored, back to entry
        clear_counts();
        for (int r = 0; r < 3; r++) begin
            press_pin(32'h1235, 4);
            press(4'd12);
        end
        wait_cyc(2);
        check("t2_err_count", 32'(err_cnt), 32'd3);
        check("t2_alarm_on",  32'(alarm),   32'd1);
        press_pin(32'h1234, 4);
        press(4'd12);
        wait_cyc(40);
        check("t2_alarm_len",   32'(alm_cnt), 32'd50);
        check("t2_no_unlock",   32'(unl_cnt), 32'd0);
        check("t2_state_entry", 32'(state_o), 32'd0);

        // 3: extra digits dropped; short entry rejected
        clear_counts();
        press_pin(32'h123456, 6);
        press(4'd12);
        wait_cyc(1);
        check("t3_long_unlock", 32'(unlocked), 32'd1);
        press(4'd10);
        clear_counts();
        press_pin(32'h12, 2);
        press(4'd12);
        wait_cyc(3);
        check("t3_short_err",    32'(err_cnt),  32'd1);
        check("t3_short_locked", 32'(unlocked), 32'd0);

        // 4: reprogram to 9876, old PIN fails, new PIN opens
        clear_counts();
        press_pin(32'h1234, 4);
        press(4'd12);
        press(4'd12);
        press_pin(32'h9876, 4);
        press(4'd12);
        wait_cyc(2);
        check("t4_prog_ok",     32'(ok_cnt),   32'd2);
        check("t4_prog_locked", 32'(unlocked), 32'd0);
        clear_counts();
        press_pin(32'h1234, 4);
        press(4'd12);
        wait_cyc(3);
        check("t4_old_pin_err", 32'(err_cnt), 32'd1);
        press_pin(32'h9876, 4);
        press(4'd12);
        wait_cyc(1);
        check("t4_new_pin_open", 32'(unlocked), 32'd1);

        // 5: '*' relocks within 2 cycles; '*' clears partial entry
        @(negedge clk);
        key_code = 4'd10;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("t5_star_relock", 32'(unlocked), 32'd0);
        key_code = 4'd15;
        wait_cyc(3);
        press(4'd1); press(4'd2); press(4'd10); press(4'd3);
        #1;
        check("t5_cnt",  32'(entry_cnt),  32'd1);
        check("t5_disp", 32'(entry_disp), 32'hFFF3);
        press(4'd10);

        // 6: held key counts once; reset discards programmed PIN
        @(negedge clk);
        key_code = 4'd7;
        repeat (10) @(negedge clk);
        key_code = 4'd15;
        wait_cyc(2);
        check("t6_held_cnt", 32'(entry_cnt), 32'd1);
        press(4'd10);
        press_pin(32'h9876, 4);
        press(4'd12);
        press(4'd12);
        press_pin(32'h1111, 4);
        press(4'd12);
        press_pin(32'h1111, 4);
        press(4'd12);
        wait_cyc(1);
        check("t6_pin1111_open", 32'(unlocked), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_rst_unlocked", 32'(unlocked),   32'd0);
        check("t6_rst_state",    32'(state_o),    32'd0);
        check("t6_rst_disp",     32'(entry_disp), 32'hFFFF);
        check("t6_rst_pulses",   32'({ok_pulse, err_pulse, alarm}), 32'd0);
        wait_cyc(2);
        @(negedge clk);
        rst_n = 1'b1;
        clear_counts();
        press_pin(32'h1234, 4);
        press(4'd12);
        wait_cyc(1);
        check("t6_default_open", 32'(unlocked), 32'd1);
        check("t6_default_ok",   32'(ok_cnt),   32'd1);

        // Random traffic against the model
        press(4'd10);
        for (int it = 0; it < 300; it++) begin
            int r, rr, hold, gap;
            logic [3:0] k;
            r = int'($urandom_range(0, 99));
            if (r < 12) begin
                for (int i = 0; i < PIN_LEN; i++) press(4'(m_pin[i]));
                press(4'd12);
            end else begin
                rr = int'($urandom_range(0, 15));
                if (rr <= 9)       k = 4'(rr);
                else if (rr == 10) k = 4'd10;
                else if (rr <= 12) k = 4'd12;
                else if (rr == 13) k = 4'd15;
                else if (rr == 14) k = 4'd11;
                else               k = 4'(13 + int'($urandom_range(0, 1)));
                hold = int'($urandom_range(1, 4));
                gap  = int'($urandom_range(0, 2));
                @(negedge clk);
                key_code = k;
                repeat (hold) @(negedge clk);
                if (gap > 0) begin
                    key_code = 4'd15;
                    repeat (gap - 1) @(negedge clk);
                end
            end
        end
        key_code = 4'd15;
        wait_cyc(60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
